conv_loop_scheduler: RTL

CONV_LOOP_SCHEDULER -- requirements
Module: conv_loop_scheduler

---
 rtl/conv_loop_scheduler.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_loop_scheduler.sv
// Convolution loop-nest scheduler: walks the tile and compute loops of one layer,
// handshaking with the ifmap/weight banks and the ofmap drain.
module conv_loop_scheduler #(
  parameter int PARAM_NUM       = 6,
  parameter int PARAM_WID       = 16,
  parameter int BANK_ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PARAM_NUM*PARAM_WID-1:0] layer_params_dat,
  input  logic                           layer_params_vld,
  output logic                           layer_params_rdy,
  input  logic                           ifmap_tile_ready,
  output logic                           ifmap_tile_release,
  input  logic                           weights_tile_ready,
  output logic                           weights_tile_release,
  output logic                           mac_en,
  output logic                           mac_clear,
  output logic [BANK_ADDR_WIDTH-1:0]     ifmap_rd_addr,
  output logic [BANK_ADDR_WIDTH-1:0]     weights_rd_addr,
  output logic                           ofmap_tile_done,
  input  logic                           ofmap_drain_done,
  output logic                           layer_done,
  output logic                           busy
);

  localparam int AW = BANK_ADDR_WIDTH;
  localparam logic [PARAM_WID-1:0] P_ZERO = {PARAM_WID{1'b0}};
  localparam logic [PARAM_WID-1:0] P_ONE  = {{(PARAM_WID-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]        A_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]        A_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_TILE = 3'd2,
    COMPUTE   = 3'd3,
    RELEASE   = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6
  } state_t;

  function automatic logic [AW-1:0] widen(input logic [PARAM_WID-1:0] v);
    widen = AW'(v);
  endfunction

  state_t state_r, state_nxt;

  logic [PARAM_WID-1:0] oy1_cfg_r, oc1_cfg_r, ic1_cfg_r, fy_cfg_r, oy0_cfg_r, stride_cfg_r;
  logic [AW-1:0]        ix0_r;
  logic [PARAM_WID-1:0] oy1_r, ox1_r, oc1_r, ic1_r;
  logic [PARAM_WID-1:0] fy_r, fx_r, oy0_r, ox0_r;
  logic                 drain_first_r;

  logic ox0_last_s, oy0_last_s, fx_last_s, fy_last_s, point_last_s;
  logic ic1_last_s, oc1_last_s, ox1_last_s, oy1_last_s, tiles_last_s;
  logic cfg_zero_s;

  logic rdy_s, release_s, mac_en_s, mac_clear_s, tile_done_s, layer_done_s, busy_s;
  logic [AW-1:0] row_s, col_s, ifmap_addr_s, weights_addr_s;

  // Loop-bound detection; FX/OX1/OX0 share the bounds of FY/OY1/OY0.
  always_comb begin
    ox0_last_s   = (ox0_r == (oy0_cfg_r - P_ONE));
    oy0_last_s   = (oy0_r == (oy0_cfg_r - P_ONE));
    fx_last_s    = (fx_r  == (fy_cfg_r  - P_ONE));
    fy_last_s    = (fy_r  == (fy_cfg_r  - P_ONE));
    point_last_s = ox0_last_s & oy0_last_s & fx_last_s & fy_last_s;
    ic1_last_s   = (ic1_r == (ic1_cfg_r - P_ONE));
    oc1_last_s   = (oc1_r == (oc1_cfg_r - P_ONE));
    ox1_last_s   = (ox1_r == (oy1_cfg_r - P_ONE));
    oy1_last_s   = (oy1_r == (oy1_cfg_r - P_ONE));
    tiles_last_s = oc1_last_s & ox1_last_s & oy1_last_s;
    cfg_zero_s   = (oy1_cfg_r == P_ZERO) | (oc1_cfg_r == P_ZERO) | (ic1_cfg_r == P_ZERO) |
                   (fy_cfg_r == P_ZERO) | (oy0_cfg_r == P_ZERO);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    state_nxt    = state_r;
    rdy_s        = 1'b0;
    release_s    = 1'b0;
    mac_en_s     = 1'b0;
    mac_clear_s  = 1'b0;
    tile_done_s  = 1'b0;
    layer_done_s = 1'b0;
    busy_s       = (state_r != IDLE);
    case (state_r)
      IDLE: begin
        rdy_s = 1'b1;
        if (layer_params_vld) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (cfg_zero_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT_TILE;
        end
      end
      WAIT_TILE: begin
        if (ifmap_tile_ready && weights_tile_ready) begin
          state_nxt = COMPUTE;
        end else begin
          state_nxt = WAIT_TILE;
        end
      end
      COMPUTE: begin
        mac_en_s    = 1'b1;
        mac_clear_s = (ic1_r == P_ZERO) & (fy_r == P_ZERO) & (fx_r == P_ZERO);
        if (point_last_s) begin
          state_nxt = RELEASE;
        end else begin
          state_nxt = COMPUTE;
        end
      end
      RELEASE: begin
        release_s = 1'b1;
        if (ic1_last_s) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = WAIT_TILE;
        end
      end
      DRAIN: begin
        tile_done_s = drain_first_r;
        if (!ofmap_drain_done) begin
          state_nxt = DRAIN;
        end else if (tiles_last_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT_TILE;
        end
      end
      DONE: begin
        layer_done_s = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bank read addresses for the current compute point; zero outside COMPUTE.
  always_comb begin
    row_s = widen(oy0_r) * widen(stride_cfg_r) + widen(fy_r);
    col_s = widen(ox0_r) * widen(stride_cfg_r) + widen(fx_r);
    if (mac_en_s) begin
      ifmap_addr_s   = row_s * ix0_r + col_s;
      weights_addr_s = widen(fy_r) * widen(fy_cfg_r) + widen(fx_r);
    end else begin
      ifmap_addr_s   = A_ZERO;
      weights_addr_s = A_ZERO;
    end
  end

  // Parameter latch, derived ifmap row pitch, and the eight loop indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oy1_cfg_r     <= P_ZERO;
      oc1_cfg_r     <= P_ZERO;
      ic1_cfg_r     <= P_ZERO;
      fy_cfg_r      <= P_ZERO;
      oy0_cfg_r     <= P_ZERO;
      stride_cfg_r  <= P_ZERO;
      ix0_r         <= A_ZERO;
      oy1_r         <= P_ZERO;
      ox1_r         <= P_ZERO;
      oc1_r         <= P_ZERO;
      ic1_r         <= P_ZERO;
      fy_r          <= P_ZERO;
      fx_r          <= P_ZERO;
      oy0_r         <= P_ZERO;
      ox0_r         <= P_ZERO;
      drain_first_r <= 1'b0;
    end else begin
      drain_first_r <= (state_r != DRAIN);
      case (state_r)
        IDLE: begin
          oy1_r <= P_ZERO;
          ox1_r <= P_ZERO;
          oc1_r <= P_ZERO;
          ic1_r <= P_ZERO;
          if (layer_params_vld) begin
            oy1_cfg_r    <= layer_params_dat[5*PARAM_WID +: PARAM_WID];
            oc1_cfg_r    <= layer_params_dat[4*PARAM_WID +: PARAM_WID];
            ic1_cfg_r    <= layer_params_dat[3*PARAM_WID +: PARAM_WID];
            fy_cfg_r     <= layer_params_dat[2*PARAM_WID +: PARAM_WID];
            oy0_cfg_r    <= layer_params_dat[1*PARAM_WID +: PARAM_WID];
            stride_cfg_r <= layer_params_dat[0 +: PARAM_WID];
          end else begin
            oy1_cfg_r <= oy1_cfg_r;
          end
        end
        LOAD: begin
          ix0_r <= (widen(oy0_cfg_r) - A_ONE) * widen(stride_cfg_r) + widen(fy_cfg_r);
        end
        WAIT_TILE: begin
          fy_r  <= P_ZERO;
          fx_r  <= P_ZERO;
          oy0_r <= P_ZERO;
          ox0_r <= P_ZERO;
        end
        COMPUTE: begin
          // ox0 fastest, then oy0, fx, fy.
          if (!ox0_last_s) begin
            ox0_r <= ox0_r + P_ONE;
          end else begin
            ox0_r <= P_ZERO;
            if (!oy0_last_s) begin
              oy0_r <= oy0_r + P_ONE;
            end else begin
              oy0_r <= P_ZERO;
              if (!fx_last_s) begin
                fx_r <= fx_r + P_ONE;
              end else begin
                fx_r <= P_ZERO;
                if (!fy_last_s) begin
                  fy_r <= fy_r + P_ONE;
                end else begin
                  fy_r <= P_ZERO;
                end
              end
            end
          end
        end
        RELEASE: begin
          if (ic1_last_s) begin
            ic1_r <= P_ZERO;
          end else begin
            ic1_r <= ic1_r + P_ONE;
          end
        end
        DRAIN: begin
          if (ofmap_drain_done) begin
            if (!oc1_last_s) begin
              oc1_r <= oc1_r + P_ONE;
            end else begin
              oc1_r <= P_ZERO;
              if (!ox1_last_s) begin
                ox1_r <= ox1_r + P_ONE;
              end else begin
                ox1_r <= P_ZERO;
                if (!oy1_last_s) begin
                  oy1_r <= oy1_r + P_ONE;
                end else begin
                  oy1_r <= P_ZERO;
                end
              end
            end
          end else begin
            oc1_r <= oc1_r;
          end
        end
        DONE: begin
          ic1_r <= P_ZERO;
        end
        default: begin
          ic1_r <= P_ZERO;
        end
      endcase
    end
  end

  assign layer_params_rdy     = rdy_s & rst_n;
  assign ifmap_tile_release   = release_s;
  assign weights_tile_release = release_s;
  assign mac_en               = mac_en_s;
  assign mac_clear            = mac_clear_s;
  assign ifmap_rd_addr        = ifmap_addr_s;
  assign weights_rd_addr      = weights_addr_s;
  assign ofmap_tile_done      = tile_done_s;
  assign layer_done           = layer_done_s;
  assign busy                 = busy_s;

endmodule
